inst_sequencer: RTL and testbench

- Front end of the accelerator control path: fetches 32-bit words from the instruction memory (64 deep, 1-cycle synchronous read) and decodes the opcode into the instruction_type encoding.
- Executes NOP, REPEAT and HALT internally.
- Hands every other instruction (MATMUL, ACCMOV, LOADMAC, …, MAT_UPDATE) to the downstream datapath controller over a valid/ready handshake.
- Sits directly upstream of the NU array control.

---
 rtl/inst_sequencer.sv | 174 +++++++++++++++++
 tb/tb_inst_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction fetch/decode sequencer with single-level REPEAT loops
// Optional SEQ_PERF_CNT_EN adds the issued_cnt handshake counter port.
module inst_sequencer #(
    parameter int INST_MEM_SIZE   = 32,
    parameter int INST_MEM_DEPTH  = 64,
    parameter int OPCODE_SIZE     = 5,
    parameter int REPEAT_CNT_SIZE = 16,
    localparam int AW = $clog2(INST_MEM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [AW-1:0]            start_addr,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     imem_rd_en,
    output logic [AW-1:0]            imem_addr,
    input  logic [INST_MEM_SIZE-1:0] imem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [3:0]               inst_op,
    output logic [26:0]              inst_arg
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE} state_t;

    localparam logic [OPCODE_SIZE-1:0] OP_HALT   = OPCODE_SIZE'(0);
    localparam logic [OPCODE_SIZE-1:0] OP_REPEAT = OPCODE_SIZE'(2);
    localparam logic [OPCODE_SIZE-1:0] OP_FIRST  = OPCODE_SIZE'(3);
    localparam logic [OPCODE_SIZE-1:0] OP_LAST   = OPCODE_SIZE'(10);

    state_t                     state, state_n;
    logic [AW-1:0]              pc, pc_n;
    logic [AW-1:0]              loop_start, loop_start_n;
    logic [AW-1:0]              loop_end, loop_end_n;
    logic [REPEAT_CNT_SIZE-1:0] loop_cnt, loop_cnt_n;
    logic                       loop_act, loop_act_n;
    logic                       err_n;
    logic [3:0]                 op_n;
    logic [26:0]                arg_n;

    logic [AW-1:0]              adv_pc;
    logic [REPEAT_CNT_SIZE-1:0] adv_cnt;
    logic                       adv_act;

    logic [OPCODE_SIZE-1:0]     opcode;
    logic [5:0]                 rep_len;
    logic [REPEAT_CNT_SIZE-1:0] rep_cnt;

    assign opcode  = imem_rdata[INST_MEM_SIZE-1 -: OPCODE_SIZE];
    assign rep_len = imem_rdata[26:21];
    assign rep_cnt = imem_rdata[REPEAT_CNT_SIZE-1:0];

    assign busy       = (state != S_IDLE);
    assign imem_rd_en = (state == S_FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == S_ISSUE);

    // Sequential pc step shared by NOP-like words and retired issues; handles the loop back-edge.
    always_comb begin
        adv_pc  = pc + AW'(1);
        adv_cnt = loop_cnt;
        adv_act = loop_act;
        if (loop_act && pc == loop_end) begin
            if (loop_cnt != '0) begin
                adv_pc  = loop_start;
                adv_cnt = loop_cnt - REPEAT_CNT_SIZE'(1);
            end else begin
                adv_act = 1'b0;
            end
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        loop_start_n = loop_start;
        loop_end_n   = loop_end;
        loop_cnt_n   = loop_cnt;
        loop_act_n   = loop_act;
        err_n        = err;
        op_n         = inst_op;
        arg_n        = inst_arg;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n    = S_FETCH;
                    pc_n       = start_addr;
                    err_n      = 1'b0;
                    loop_act_n = 1'b0;
                end
            end
            S_FETCH: state_n = S_DECODE;
            S_DECODE: begin
                state_n = S_FETCH;
                if (opcode == OP_HALT) begin
                    done    = 1'b1;
                    state_n = S_IDLE;
                end else if (opcode >= OP_FIRST && opcode <= OP_LAST) begin
                    op_n    = opcode[3:0];
                    arg_n   = imem_rdata[26:0];
                    state_n = S_ISSUE;
                end else if (opcode == OP_REPEAT && !loop_act && rep_cnt == '0) begin
                    pc_n = pc + AW'(rep_len) + AW'(1);
                end else if (opcode == OP_REPEAT && !loop_act && rep_len != '0) begin
                    loop_start_n = pc + AW'(1);
                    loop_end_n   = pc + AW'(rep_len);
                    loop_cnt_n   = rep_cnt - REPEAT_CNT_SIZE'(1);
                    loop_act_n   = 1'b1;
                    pc_n         = pc + AW'(1);
                end else begin
                    // NOP, zero-length REPEAT, nested REPEAT and unknown opcodes all step like NOP.
                    pc_n       = adv_pc;
                    loop_cnt_n = adv_cnt;
                    loop_act_n = adv_act;
                    if (opcode > OP_LAST || (opcode == OP_REPEAT && loop_act))
                        err_n = 1'b1;
                end
            end
            S_ISSUE: begin
                if (inst_ready) begin
                    pc_n       = adv_pc;
                    loop_cnt_n = adv_cnt;
                    loop_act_n = adv_act;
                    state_n    = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            loop_start <= '0;
            loop_end   <= '0;
            loop_cnt   <= '0;
            loop_act   <= 1'b0;
            err        <= 1'b0;
            inst_op    <= '0;
            inst_arg   <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            loop_start <= loop_start_n;
            loop_end   <= loop_end_n;
            loop_cnt   <= loop_cnt_n;
            loop_act   <= loop_act_n;
            err        <= err_n;
            inst_op    <= op_n;
            inst_arg   <= arg_n;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            issued_cnt <= '0;
        end else if (state == S_ISSUE && inst_ready && issued_cnt != 16'hFFFF) begin
            issued_cnt <= issued_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - directed and randomized checks of inst_sequencer against an interpreter model
// Honours SEQ_PERF_CNT_EN when the design is built with it.
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  start_addr = '0;
    logic        busy, done, err, imem_rd_en, inst_valid;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        inst_ready = 1'b0;
    logic [3:0]  inst_op;
    logic [26:0] inst_arg;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] issued_cnt;
`endif

    logic [31:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    logic [30:0] exp_q [$];
    logic [30:0] hs_q  [$];
    int          exp_cyc;
    bit          exp_err;
    bit          exp_halted;

    inst_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .imem_rd_en (imem_rd_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_op    (inst_op),
        .inst_arg   (inst_arg)
`ifdef SEQ_PERF_CNT_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int arg);
        logic [31:0] w;
        w = {5'(op), 27'(arg)};
        return w;
    endfunction

    function automatic logic [31:0] rep(input int len, input int cnt);
        logic [31:0] w;
        w = {5'd2, 6'(len), 5'd0, 16'(cnt)};
        return w;
    endfunction

    // Software interpreter: walks the program word by word, counting 2 cycles per
    // non-issued word (HALT included) and 3 per issued word with ready always high.
    task automatic model_run(input int sa);
        int pc, op, body_first, body_last, iters_left;
        bit in_loop;
        logic [31:0] w;
        pc = sa; in_loop = 0; body_first = 0; body_last = 0; iters_left = 0;
        exp_q.delete(); exp_err = 0; exp_cyc = 0; exp_halted = 0;
        for (int step = 0; step < 200; step++) begin
            w  = mem[pc];
            op = int'(w[31:27]);
            if (op == 0) begin
                exp_cyc += 2;
                exp_halted = 1;
                return;
            end
            if (op >= 3 && op <= 10) begin
                exp_q.push_back({w[30:27], w[26:0]});
                exp_cyc += 3;
            end else begin
                exp_cyc += 2;
                if (op == 2 && !in_loop && w[15:0] == 0) begin
                    pc = (pc + int'(w[26:21]) + 1) % 64;
                    continue;
                end
                if (op == 2 && !in_loop && w[26:21] != 0) begin
                    in_loop    = 1;
                    body_first = (pc + 1) % 64;
                    body_last  = (pc + int'(w[26:21])) % 64;
                    iters_left = int'(w[15:0]);
                    pc = body_first;
                    continue;
                end
                if (op > 10 || (op == 2 && in_loop)) exp_err = 1;
            end
            if (in_loop && pc == body_last) begin
                iters_left--;
                if (iters_left > 0) pc = body_first;
                else begin
                    in_loop = 0;
                    pc = (pc + 1) % 64;
                end
            end else begin
                pc = (pc + 1) % 64;
            end
        end
    endtask

    // rmode: 0 ready tied high, 1 random ready, 2 first issue stalled 10 cycles
    task automatic run_prog(input string name, input int sa, input int rmode);
        int cyc, done_cyc, stall, bound;
        bit got_done, pvalid, hs_last, hs_now;
        logic [3:0]  pop;
        logic [26:0] parg;
        model_run(sa);
        bound = 4 * exp_cyc + 100;
        hs_q.delete();
        stall = 0; pvalid = 0; hs_last = 0; got_done = 0; done_cyc = 0;
        pop = '0; parg = '0;
        @(negedge clk);
        start = 1'b1; start_addr = 6'(sa); inst_ready = (rmode != 1);
        @(posedge clk);
        cyc = 0;
        while (!got_done && cyc < bound) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                chk({name, ".busy_start"}, 64'(busy), 64'd1);
                chk({name, ".err_clr"}, 64'(err), 64'd0);
            end
            if (pvalid && !hs_last) begin
                chk({name, ".hold_valid"}, 64'(inst_valid), 64'd1);
                chk({name, ".hold_op"}, 64'(inst_op), 64'(pop));
                chk({name, ".hold_arg"}, 64'(inst_arg), 64'(parg));
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            case (rmode)
                0: inst_ready = 1'b1;
                1: inst_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (inst_valid && stall < 10) begin
                        inst_ready = 1'b0;
                        stall++;
                    end else begin
                        inst_ready = 1'b1;
                    end
                end
            endcase
            hs_now = inst_valid && inst_ready;
            if (hs_now) hs_q.push_back({inst_op[2:0] == inst_op[2:0] ? inst_op[3:0] : 4'h0, inst_arg});
            pvalid = inst_valid; pop = inst_op; parg = inst_arg; hs_last = hs_now;
        end
        chk({name, ".done_seen"}, 64'(got_done), 64'd1);
        chk({name, ".n_issue"}, 64'(hs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
            chk($sformatf("%s.issue%0d", name, i), 64'(hs_q[i]), 64'(exp_q[i]));
        chk({name, ".err"}, 64'(err), 64'(exp_err));
        if (rmode == 0) chk({name, ".done_cyc"}, 64'(done_cyc), 64'(exp_cyc));
`ifdef SEQ_PERF_CNT_EN
        chk({name, ".issued_cnt"}, 64'(issued_cnt), 64'(exp_q.size()));
`endif
        @(negedge clk);
        chk({name, ".busy_after"}, 64'(busy), 64'd0);
        chk({name, ".done_after"}, 64'(done), 64'd0);
        inst_ready = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 99);
        if (r < 6)  return 32'h0;
        if (r < 20) return enc(1, int'($urandom));
        if (r < 32) return rep(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        if (r < 40) return enc(int'($urandom_range(11, 31)), int'($urandom));
        return enc(int'($urandom_range(3, 10)), int'($urandom));
    endfunction

    initial begin
        int sa;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk("rst.rd_en", 64'(imem_rd_en), 64'd0);
        chk("rst.addr", 64'(imem_addr), 64'd0);
        chk("rst.valid", 64'(inst_valid), 64'd0);
        chk("rst.op", 64'(inst_op), 64'd0);
        chk("rst.arg", 64'(inst_arg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        clear_mem();
        mem[0] = enc(3, 'h123);
        mem[1] = 32'h0;
        run_prog("matmul", 0, 0);
        chk("matmul.cyc5", 64'(exp_cyc), 64'd5);

        clear_mem();
        mem[4] = rep(2, 3);
        mem[5] = enc(5, 'h55);
        mem[6] = enc(9, 'h99);
        mem[7] = 32'h0;
        run_prog("loop", 4, 0);

        clear_mem();
        mem[0] = rep(2, 0);
        mem[1] = enc(4, 1);
        mem[2] = enc(4, 2);
        mem[3] = 32'h0;
        run_prog("skip", 0, 0);

        clear_mem();
        mem[0] = rep(0, 5);
        mem[1] = enc(3, 'h7);
        mem[2] = 32'h0;
        run_prog("len0", 0, 0);

        clear_mem();
        mem[0] = enc(4, 'h4abcde);
        mem[1] = 32'h0;
        run_prog("stall", 0, 2);

        clear_mem();
        mem[0] = rep(3, 2);
        mem[1] = enc(4, 'h11);
        mem[2] = enc(31, 'h3);
        mem[3] = rep(1, 1);
        mem[4] = enc(3, 'h22);
        mem[5] = 32'h0;
        run_prog("errs", 0, 0);
        clear_mem();
        mem[10] = enc(6, 'h66);
        mem[11] = 32'h0;
        run_prog("clean", 10, 0);

        clear_mem();
        mem[63] = enc(1, 0);
        mem[0]  = 32'h0;
        run_prog("wrap", 63, 0);

        for (int t = 0; t < 30; t++) begin
            sa = 0;
            for (int tries = 0; tries < 20; tries++) begin
                for (int i = 0; i < 64; i++) mem[i] = rand_word();
                sa = int'($urandom_range(0, 63));
                model_run(sa);
                if (exp_halted) break;
            end
            if (!exp_halted) mem[sa] = 32'h0;
            run_prog($sformatf("rnd%0d", t), sa, (t % 3 == 0) ? 0 : 1);
        end

        clear_mem();
        mem[0] = enc(4, 'h1234);
        mem[1] = 32'h0;
        @(negedge clk);
        start = 1'b1; start_addr = 6'd0; inst_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 10 && !inst_valid; i++) @(negedge clk);
        chk("rstiss.valid_pre", 64'(inst_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstiss.valid", 64'(inst_valid), 64'd0);
        chk("rstiss.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_prog("after_rst", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
